// File: rtl/dac_pulse_pkg.sv
// Shared types and frame formatting for the multi-channel DAC pulse sequencer.
package dac_pulse_pkg;

    localparam logic [3:0]  CMD_WRITE   = 4'b0000;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned MAX_DATA_W  = 32;
    localparam int unsigned MAX_FRAME_W = 8 + MAX_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_STROBE, ST_HOLD, ST_DONE
    } seq_state_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_LEAD, TX_SHIFT, TX_TRAIL, TX_GAP
    } tx_state_e;

    // Right-aligned {CMD_WRITE, addr, code}; caller truncates to 8+data_w bits.
    function automatic logic [MAX_FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0]     addr,
        input logic [MAX_DATA_W-1:0] code,
        input int unsigned           data_w
    );
        logic [MAX_FRAME_W-1:0] hdr;
        hdr = MAX_FRAME_W'({CMD_WRITE, addr});
        return (hdr << data_w) | MAX_FRAME_W'(code);
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Single-frame SPI transmitter: clock-enable sck divider, MSB-first shift,
// ss_n lead/trail of one half-period, then an inter-frame gap before ready.
module spi_frame_tx
    import dac_pulse_pkg::*;
#(
    parameter int unsigned FRAME_W = 24,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               ready_o,
    output logic               sck_o,
    output logic               mosi_o,
    output logic               ss_n_o
);

    localparam int unsigned CNT_W = $clog2(2 * CLK_DIV) + 1;
    localparam int unsigned BIT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(2 * CLK_DIV - 1);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               sck_q, sck_d;
    logic               ss_n_q, ss_n_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sck_q   <= 1'b0;
            ss_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sck_q   <= sck_d;
            ss_n_q  <= ss_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sck_d   = sck_q;
        ss_n_d  = ss_n_q;
        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    sh_d    = frame_i;
                    ss_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = TX_LEAD;
                end
            end
            TX_LEAD: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    bit_d   = BIT_W'(FRAME_W - 1);
                    state_d = TX_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_SHIFT: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        // mosi is the shift register MSB, so it only moves on falling sck
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = TX_TRAIL;
                        end else begin
                            sh_d  = sh_q << 1;
                            bit_d = bit_q - 1'b1;
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_TRAIL: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    sh_d    = '0;
                    state_d = TX_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign ready_o = (state_q == TX_IDLE);
    assign sck_o   = sck_q;
    assign mosi_o  = sh_q[FRAME_W-1];
    assign ss_n_o  = ss_n_q;

endmodule

// File: rtl/dac_pulse_seq.sv
// Multi-channel DAC pulse sequencer: set codes + LDAC, hold, restore + LDAC.
// Optional CH_MASK_EN adds ch_mask to skip channels in both phases.
module dac_pulse_seq
    import dac_pulse_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned TICK_DIV  = 1024,
    parameter int unsigned WIDTH_W   = 16,
    parameter logic [DATA_W-1:0] IDLE_CODE = '0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     trigger,
    input  logic [NUM_CH*DATA_W-1:0] current,
    input  logic [WIDTH_W-1:0]       width,
`ifdef CH_MASK_EN
    input  logic [NUM_CH-1:0]        ch_mask,
`endif
    output logic                     sck,
    output logic                     mosi,
    output logic                     ss_n,
    output logic                     ldac_n,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int unsigned FRAME_W = 8 + DATA_W;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SC_W    = $clog2(2 * CLK_DIV) + 1;
    localparam int unsigned PRE_W   = $clog2(TICK_DIV);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [SC_W-1:0]  STROBE_END = SC_W'(2 * CLK_DIV - 1);
    localparam logic [PRE_W-1:0] TICK_END   = PRE_W'(TICK_DIV - 1);

    seq_state_e               state_q, state_d;
    logic                     phase_q, phase_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [SC_W-1:0]          cnt_q, cnt_d;
    logic [PRE_W-1:0]         pre_q, pre_d;
    logic [WIDTH_W-1:0]       tick_q, tick_d;
    logic [NUM_CH*DATA_W-1:0] cur_q, cur_d;
    logic [WIDTH_W-1:0]       width_q, width_d;
    logic [NUM_CH-1:0]        mask_q, mask_d, mask_in;
    logic                     trig_d1_q;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     ldac_n_q, ldac_n_d, ovr_q, ovr_d;

    logic                     trig_edge, ch_en, any_ch, last_ch;
    logic                     tx_start, tx_ready, tx_ss_n;
    logic [DATA_W-1:0]        code_sel;
    logic [FRAME_W-1:0]       frame;

`ifdef CH_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = '1;
`endif

    assign trig_edge = trigger & ~trig_d1_q;
    assign ch_en     = mask_q[ch_q];
    assign any_ch    = |mask_q;
    assign last_ch   = (ch_q == LAST_CH);
    assign code_sel  = phase_q ? IDLE_CODE : cur_q[int'(ch_q)*DATA_W +: DATA_W];
    assign frame     = FRAME_W'(build_frame(ADDR_W'(ch_q), MAX_DATA_W'(code_sel), DATA_W));

    spi_frame_tx #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (tx_start),
        .frame_i (frame),
        .ready_o (tx_ready),
        .sck_o   (sck),
        .mosi_o  (mosi),
        .ss_n_o  (tx_ss_n)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            ch_q      <= '0;
            cnt_q     <= '0;
            pre_q     <= '0;
            tick_q    <= '0;
            cur_q     <= '0;
            width_q   <= '0;
            mask_q    <= '0;
            trig_d1_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ldac_n_q  <= 1'b1;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            cur_q     <= cur_d;
            width_q   <= width_d;
            mask_q    <= mask_d;
            trig_d1_q <= trigger;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ldac_n_q  <= ldac_n_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        tick_d   = tick_q;
        cur_d    = cur_q;
        width_d  = width_q;
        mask_d   = mask_q;
        ovr_d    = ovr_q;
        tx_start = 1'b0;
        if (trig_edge && state_q != ST_IDLE) ovr_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    cur_d   = current;
                    width_d = width;
                    mask_d  = mask_in;
                    ovr_d   = 1'b0;
                    phase_d = 1'b0;
                    ch_d    = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!any_ch) begin
                    state_d = ST_DONE;
                end else if (ch_en) begin
                    tx_start = 1'b1;
                    state_d  = ST_SHIFT;
                end else if (last_ch) begin
                    ch_d    = '0;
                    state_d = ST_STROBE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            ST_SHIFT: if (tx_ss_n) state_d = ST_GAP;
            ST_GAP: begin
                if (tx_ready) begin
                    if (last_ch) begin
                        ch_d    = '0;
                        state_d = ST_STROBE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_END) begin
                    cnt_d = '0;
                    if (phase_q) begin
                        state_d = ST_DONE;
                    end else if (width_q == '0) begin
                        phase_d = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        pre_d   = '0;
                        tick_d  = '0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (pre_q == TICK_END) begin
                    pre_d = '0;
                    if (tick_q == width_q - 1'b1) begin
                        phase_d = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d   = !(state_d inside {ST_IDLE, ST_DONE});
        done_d   = (state_d == ST_DONE);
        ldac_n_d = (state_d != ST_STROBE);
    end

    assign ss_n    = tx_ss_n;
    assign ldac_n  = ldac_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_dac_pulse_seq.sv
// Directed bench for dac_pulse_seq (NUM_CH=4, DATA_W=16, CLK_DIV=2, TICK_DIV=1024).
module tb_dac_pulse_seq;

    localparam int unsigned NUM_CH = 4, DATA_W = 16, CLK_DIV = 2, TICK_DIV = 1024, WIDTH_W = 16;

    logic        clk = 1'b0, rstn = 1'b0, trigger = 1'b0;
    logic [63:0] current = '0;
    logic [15:0] width = '0;
    logic [3:0]  ch_mask = 4'hF;
    logic        sck, mosi, ss_n, ldac_n, busy, done, overrun;

    always #5 clk = ~clk;

    dac_pulse_seq #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
        .TICK_DIV(TICK_DIV), .WIDTH_W(WIDTH_W), .IDLE_CODE(16'h0000)
    ) dut (
        .clk(clk), .rstn(rstn), .trigger(trigger), .current(current), .width(width),
`ifdef CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .sck(sck), .mosi(mosi), .ss_n(ss_n), .ldac_n(ldac_n),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // Bus monitor, sampled on the falling clk edge
    int unsigned cyc = 0, done_pulses = 0, timing_bad = 0;
    int unsigned t_ssfall = 0, t_lastfall = 0;
    bit          first_rise = 1'b0;
    logic        p_sck = 1'b0, p_ssn = 1'b1, p_ldac = 1'b1;
    logic [31:0] sh = '0;
    int unsigned nbits = 0;
    logic [31:0] frames[$];
    int unsigned fbits[$], ssn_fall[$], ldac_fall[$], ldac_rise[$];

    always @(negedge clk) begin
        cyc++;
        if (!ss_n && p_ssn) begin
            ssn_fall.push_back(cyc); t_ssfall = cyc; nbits = 0; sh = '0; first_rise = 1'b1;
        end
        if (sck && !p_sck && !ss_n) begin
            sh = {sh[30:0], mosi}; nbits++;
            if (first_rise) begin
                if (cyc - t_ssfall != CLK_DIV) timing_bad++;
                first_rise = 1'b0;
            end
        end
        if (!sck && p_sck) t_lastfall = cyc;
        if (ss_n && !p_ssn) begin
            frames.push_back(sh); fbits.push_back(nbits);
            if (cyc - t_lastfall != CLK_DIV) timing_bad++;
        end
        if (!ldac_n && p_ldac) ldac_fall.push_back(cyc);
        if (ldac_n && !p_ldac) ldac_rise.push_back(cyc);
        if (done) done_pulses++;
        p_sck = sck; p_ssn = ss_n; p_ldac = ldac_n;
    end

    int unsigned n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        frames.delete(); fbits.delete(); ssn_fall.delete();
        ldac_fall.delete(); ldac_rise.delete();
        done_pulses = 0; timing_bad = 0;
    endtask

    task automatic fire();
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (done_pulses == 0 && n < 20000) begin @(negedge clk); n++; end
        chk({tag, "_done_seen"}, 64'(done_pulses != 0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input logic [63:0] c, input logic [3:0] m,
                             input int unsigned exp_hold);
        logic [31:0] exp[$];
        int unsigned hold;
        for (int ph = 0; ph < 2; ph++)
            for (int i = 0; i < 4; i++)
                if (m[i]) exp.push_back({8'h00, 4'h0, 4'(i), (ph == 1) ? 16'h0000 : c[i*16 +: 16]});
        chk({tag, "_nframes"}, 64'(frames.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            chk($sformatf("%s_frame%0d", tag, k),
                (k < frames.size()) ? {24'h0, 8'(fbits[k]), frames[k]} : 64'hx,
                {24'h0, 8'd24, exp[k]});
        if (m != 4'h0) begin
            chk({tag, "_nldac"}, 64'(ldac_fall.size()), 64'd2);
            if (ldac_fall.size() == 2 && ldac_rise.size() == 2) begin
                chk({tag, "_ldac_low0"}, 64'(ldac_rise[0] - ldac_fall[0]), 64'd4);
                chk({tag, "_ldac_low1"}, 64'(ldac_rise[1] - ldac_fall[1]), 64'd4);
                hold = 0;
                foreach (ssn_fall[j]) if (hold == 0 && ssn_fall[j] > ldac_rise[0]) hold = ssn_fall[j] - ldac_rise[0];
                chk({tag, "_hold"}, 64'(hold), 64'(exp_hold));
            end
        end
        chk({tag, "_done_pulses"}, 64'(done_pulses), 64'd1);
        chk({tag, "_sck_timing"}, 64'(timing_bad), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [63:0] cur;
        logic [15:0] w;
        int unsigned hold;
    } vec_t;
    vec_t vecs[3];

    initial begin
        int unsigned n;
        vecs[0] = '{64'h4444_3333_2222_1111, 16'd3, 3073};
        vecs[1] = '{64'hDEAD_BEEF_0001_8000, 16'd0, 1};
        vecs[2] = '{64'hFFFF_0000_A5A5_5A5A, 16'd1, 1025};

        repeat (3) @(negedge clk);
        chk("reset_outs", {57'h0, sck, mosi, ss_n, ldac_n, busy, done, overrun}, 64'b0011000);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            clear_mon();
            current = vecs[v].cur; width = vecs[v].w; ch_mask = 4'hF;
            fire();
            chk($sformatf("v%0d_busy_start", v), 64'(busy), 64'd1);
            wait_done($sformatf("v%0d", v));
            check_seq($sformatf("v%0d", v), vecs[v].cur, 4'hF, vecs[v].hold);
        end

        // Extra trigger edge during HOLD: ignored, flagged, timing intact
        clear_mon();
        current = 64'h4444_3333_2222_1111; width = 16'd3;
        fire();
        n = 0;
        while (ldac_rise.size() == 0 && n < 20000) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        fire();
        chk("ovr_set", {62'h0, overrun, busy}, 64'b11);
        wait_done("ovr");
        check_seq("ovr", 64'h4444_3333_2222_1111, 4'hF, 3073);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Accepted trigger clears overrun; input change mid-SHIFT must not leak
        clear_mon();
        current = 64'h0123_4567_89AB_CDEF; width = 16'd0;
        fire();
        chk("ovr_cleared", 64'(overrun), 64'd0);
        repeat (30) @(negedge clk);
        current = '1;
        wait_done("latch");
        check_seq("latch", 64'h0123_4567_89AB_CDEF, 4'hF, 1);

        // Reset during frame 2 aborts immediately
        clear_mon();
        current = 64'h4444_3333_2222_1111; width = 16'd0;
        fire();
        n = 0;
        while (ssn_fall.size() < 2 && n < 20000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("abort_outs", {57'h0, sck, mosi, ss_n, ldac_n, busy, done, overrun}, 64'b0011000);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        current = 64'h1234_5678_9ABC_DEF0; width = 16'd0;
        fire();
        wait_done("post_rst");
        check_seq("post_rst", 64'h1234_5678_9ABC_DEF0, 4'hF, 1);

`ifdef CH_MASK_EN
        clear_mon();
        current = 64'h4444_3333_2222_1111; width = 16'd0; ch_mask = 4'b0101;
        fire();
        wait_done("mask5");
        check_seq("mask5", 64'h4444_3333_2222_1111, 4'b0101, 1);

        clear_mon();
        ch_mask = 4'b0000;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        chk("mask0_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("mask0_done_2clk", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        chk("mask0_no_frames", 64'(ssn_fall.size() + ldac_fall.size()), 64'd0);
        chk("mask0_pulses", 64'(done_pulses), 64'd1);
        ch_mask = 4'hF;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
